// File: rtl/wdm_pkg.sv
// rtl/wdm_pkg.sv - WDM wave bundle types, detector FSM states and passband helper
//
// Contents:
//   wave_t      : one optical lane (wavelength in nm, power in W)
//   waves8_t    : eight-lane wave bundle
//   pd_state_e  : photodetector array FSM states
//   wvl_in_band : 1 when |wvl - ref_wvl| <= tol (edges inclusive)
package wdm_pkg;

   localparam int WDM_LANES = 8;

   typedef struct {
      real wavelength;
      real power;
   } wave_t;

   typedef wave_t waves8_t [WDM_LANES];

   typedef enum logic [1:0] {
      PD_IDLE,
      PD_ACQ,
      PD_DONE
   } pd_state_e;

   function automatic bit wvl_in_band(real wvl, real ref_wvl, real tol);
      real d;
      d = wvl - ref_wvl;
      if (d < 0.0) d = -d;
      return (d <= tol);
   endfunction

endpackage

// File: rtl/photodetector_array_if.sv
// rtl/photodetector_array_if.sv - acquisition control and result handshake bundle
//
// Signals:
//   i_acq_start       : request one integration window
//   i_ready           : consumer accepts the pending result
//   o_busy            : array is integrating
//   o_valid           : result available
//   o_real_pd_current : averaged photocurrent per lane
//   o_in_band         : lane stayed in band for the whole window
//   o_overrun         : sticky, a start was dropped while a result was pending
// Modports: slave (detector array side), master (digital control side).
interface photodetector_array_if #(
   parameter int NUM_WAVES = 8
);
   logic                 i_acq_start;
   logic                 i_ready;
   logic                 o_busy;
   logic                 o_valid;
   logic                 o_overrun;
   logic [NUM_WAVES-1:0] o_in_band;
   real                  o_real_pd_current [NUM_WAVES];

   modport slave (
      input  i_acq_start,
      input  i_ready,
      output o_busy,
      output o_valid,
      output o_overrun,
      output o_in_band,
      output o_real_pd_current
   );

   modport master (
      output i_acq_start,
      output i_ready,
      input  o_busy,
      input  o_valid,
      input  o_overrun,
      input  o_in_band,
      input  o_real_pd_current
   );
endinterface

// File: rtl/photodetector_array_lane.sv
// rtl/photodetector_array_lane.sv - per-lane wavelength-selective power integrator
//
// Module pd_lane_integrator
// Ports:
//   i_clk          : clock
//   i_clear        : synchronous clear of accumulator and in-band count
//   i_acc_en       : accumulate strobe (one sample per asserted cycle)
//   i_wave         : this lane's optical sample
//   i_real_ref     : detector centre wavelength (nm)
//   i_real_tol     : passband half-width (nm)
//   o_real_acc     : sum of in-band power over the window
//   o_inband_cnt   : number of in-band samples in the window
module pd_lane_integrator
   import wdm_pkg::*;
#(
   parameter int CntW = 5
) (
   input  logic            i_clk,
   input  logic            i_clear,
   input  logic            i_acc_en,
   input  wave_t           i_wave,
   input  real             i_real_ref,
   input  real             i_real_tol,
   output real             o_real_acc,
   output logic [CntW-1:0] o_inband_cnt
);

   real             r_acc;
   logic [CntW-1:0] r_cnt;
   logic            w_in_band;

   assign w_in_band = wvl_in_band(i_wave.wavelength, i_real_ref, i_real_tol);

   // Clear wins over accumulate so a new window always starts from zero.
   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         r_acc <= 0.0;
         r_cnt <= '0;
      end else if (i_acc_en && w_in_band) begin
         r_acc <= r_acc + i_wave.power;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_real_acc   = r_acc;
   assign o_inband_cnt = r_cnt;

endmodule

// File: rtl/photodetector_array.sv
// rtl/photodetector_array.sv - WDM photodetector array with windowed averaging
//
// Optional feature macro: PD_DARK_CURRENT_EN (adds DarkCurrent offset at dump
// and the o_real_dark_total output).
// Ports:
//   i_clk             : clock
//   i_rst             : synchronous active-high reset
//   i_phot_waves      : incoming optical bundle (wavelength, power per lane)
//   i_real_ref_wvl    : per-detector centre wavelength (nm)
//   io_pd             : control/result handshake (photodetector_array_if.slave)
//   o_real_dark_total : NUM_WAVES*DarkCurrent, 0.0 during reset (feature only)
module photodetector_array
   import wdm_pkg::*;
#(
   parameter type waves_t      = waves8_t,
   parameter int  NUM_WAVES    = 8,
   parameter int  WindowLen    = 16,
   parameter real WvlTol       = 0.4,
   parameter real Responsivity = 1.0
`ifdef PD_DARK_CURRENT_EN
   ,
   parameter real DarkCurrent  = 1.0e-3
`endif
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  waves_t                 i_phot_waves,
   input  real                    i_real_ref_wvl [NUM_WAVES],
   photodetector_array_if.slave   io_pd
`ifdef PD_DARK_CURRENT_EN
   ,
   output real                    o_real_dark_total
`endif
);

   localparam int CntW = $clog2(WindowLen + 1);

   pd_state_e            r_state;
   logic [CntW-1:0]      r_cnt;
   logic                 r_busy;
   logic                 r_valid;
   logic                 r_overrun;
   logic [NUM_WAVES-1:0] r_in_band;
   real                  r_real_cur [NUM_WAVES];

   logic                 w_clear;
   logic                 w_acc_en;
   real                  w_real_acc [NUM_WAVES];
   logic [CntW-1:0]      w_inband_cnt [NUM_WAVES];

   // Accumulators clear on the edge a window is accepted: from IDLE, or on a
   // handshake cycle that immediately starts the next window.
   assign w_clear  = i_rst
                   || ((r_state == PD_IDLE) && io_pd.i_acq_start)
                   || ((r_state == PD_DONE) && r_valid && io_pd.i_ready && io_pd.i_acq_start);
   assign w_acc_en = (r_state == PD_ACQ);

   for (genvar g = 0; g < NUM_WAVES; g++) begin : g_lane
      pd_lane_integrator #(
         .CntW (CntW)
      ) u_lane (
         .i_clk        (i_clk),
         .i_clear      (w_clear),
         .i_acc_en     (w_acc_en),
         .i_wave       (i_phot_waves[g]),
         .i_real_ref   (i_real_ref_wvl[g]),
         .i_real_tol   (WvlTol),
         .o_real_acc   (w_real_acc[g]),
         .o_inband_cnt (w_inband_cnt[g])
      );
   end

   // DONE spends its first cycle dumping: the final sample lands in the
   // accumulators on the same edge that enters DONE, so scaling waits one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= PD_IDLE;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_in_band <= '0;
         for (int i = 0; i < NUM_WAVES; i++) r_real_cur[i] <= 0.0;
      end else begin
         case (r_state)
            PD_IDLE: begin
               if (io_pd.i_acq_start) begin
                  r_state <= PD_ACQ;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            PD_ACQ: begin
               if (r_cnt == CntW'(WindowLen - 1)) begin
                  r_state <= PD_DONE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            PD_DONE: begin
               if (!r_valid) begin
                  r_valid <= 1'b1;
                  for (int i = 0; i < NUM_WAVES; i++) begin
`ifdef PD_DARK_CURRENT_EN
                     r_real_cur[i] <= Responsivity * w_real_acc[i] / real'(WindowLen)
                                    + DarkCurrent;
`else
                     r_real_cur[i] <= Responsivity * w_real_acc[i] / real'(WindowLen);
`endif
                     r_in_band[i]  <= (w_inband_cnt[i] == CntW'(WindowLen));
                  end
                  if (io_pd.i_acq_start) r_overrun <= 1'b1;
               end else if (io_pd.i_ready) begin
                  r_valid <= 1'b0;
                  if (io_pd.i_acq_start) begin
                     r_state <= PD_ACQ;
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= PD_IDLE;
                  end
               end else if (io_pd.i_acq_start) begin
                  r_overrun <= 1'b1;
               end
            end
            default: begin
               r_state <= PD_IDLE;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign io_pd.o_busy            = r_busy;
   assign io_pd.o_valid           = r_valid;
   assign io_pd.o_overrun         = r_overrun;
   assign io_pd.o_in_band         = r_in_band;
   assign io_pd.o_real_pd_current = r_real_cur;

`ifdef PD_DARK_CURRENT_EN
   assign o_real_dark_total = i_rst ? 0.0 : real'(NUM_WAVES) * DarkCurrent;
`endif

endmodule

// File: tb/tb_photodetector_array.sv
// tb/tb_photodetector_array.sv - directed self-checking bench for photodetector_array
module tb_photodetector_array;
   import wdm_pkg::*;

   localparam int  NW = 8;
   localparam int  W  = 16;

   logic    clk;
   logic    rst;
   waves8_t waves;
   real     refs [NW];
   int      n_cmp;
   int      n_err;
`ifdef PD_DARK_CURRENT_EN
   real     dark_total;
`endif

   photodetector_array_if #(.NUM_WAVES(NW)) pd ();

   photodetector_array #(
      .waves_t      (waves8_t),
      .NUM_WAVES    (NW),
      .WindowLen    (W),
      .WvlTol       (0.4),
      .Responsivity (1.0)
   ) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_phot_waves      (waves),
      .i_real_ref_wvl    (refs),
      .io_pd             (pd.slave)
`ifdef PD_DARK_CURRENT_EN
      ,
      .o_real_dark_total (dark_total)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input real obs, input real exp_v);
      real d;
      n_cmp++;
      d = obs - exp_v;
      if (d < 0.0) d = -d;
      if (d > 1.0e-9) begin
         n_err++;
         $display("FAIL %s: got %g expected %g", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nominal(input real pwr);
      for (int i = 0; i < NW; i++) begin
         waves[i].wavelength = 1550.0 + 0.8 * i;
         waves[i].power      = pwr;
         refs[i]             = 1550.0 + 0.8 * i;
      end
   endtask

   // Start pulse at edge T, samples at T+1..T+W, valid after T+W+1.
   // Lane 3 is detuned by 0.5 nm for the first off_samples samples.
   task automatic run_window(input string tag, input int off_samples);
      pd.i_acq_start = 1'b1;
      tick();
      pd.i_acq_start = 1'b0;
      chk({tag, "_busy"}, real'(pd.o_busy), 1.0);
      for (int k = 1; k <= W; k++) begin
         waves[3].wavelength = refs[3] + ((k <= off_samples) ? 0.5 : 0.0);
         tick();
      end
      chk({tag, "_valid_early"}, real'(pd.o_valid), 0.0);
      tick();
      chk({tag, "_valid"}, real'(pd.o_valid), 1.0);
   endtask

   task automatic retire();
      pd.i_ready = 1'b1;
      tick();
      pd.i_ready = 1'b0;
   endtask

   initial begin
      n_cmp          = 0;
      n_err          = 0;
      rst            = 1'b1;
      pd.i_acq_start = 1'b0;
      pd.i_ready     = 1'b0;
      set_nominal(2.0);
      tick();
      tick();
`ifdef PD_DARK_CURRENT_EN
      chk("dark_total_rst", dark_total, 0.0);
`endif
      rst = 1'b0;
      tick();

      // reset state
      chk("rst_valid",   real'(pd.o_valid),   0.0);
      chk("rst_busy",    real'(pd.o_busy),    0.0);
      chk("rst_overrun", real'(pd.o_overrun), 0.0);
      chk("rst_inband",  real'(pd.o_in_band), 0.0);
      chk("rst_cur0",    pd.o_real_pd_current[0], 0.0);

`ifndef PD_DARK_CURRENT_EN
      // nominal window: every lane centred, 2.0 W
      run_window("w1", 0);
      for (int i = 0; i < NW; i++) chk($sformatf("w1_cur%0d", i), pd.o_real_pd_current[i], 2.0);
      chk("w1_inband", real'(pd.o_in_band), 255.0);
      retire();
      chk("w1_retired", real'(pd.o_valid), 0.0);
      chk("w1_hold_cur", pd.o_real_pd_current[5], 2.0);

      // lane 3 detuned for 4 of 16 samples: 12*2.0/16 = 1.5
      run_window("w2", 4);
      chk("w2_cur3",   pd.o_real_pd_current[3], 1.5);
      chk("w2_cur2",   pd.o_real_pd_current[2], 2.0);
      chk("w2_cur4",   pd.o_real_pd_current[4], 2.0);
      chk("w2_inband", real'(pd.o_in_band), 247.0);

      // pending result, start dropped -> overrun, outputs held
      pd.i_acq_start = 1'b1;
      tick();
      pd.i_acq_start = 1'b0;
      chk("ov_flag",  real'(pd.o_overrun), 1.0);
      chk("ov_valid", real'(pd.o_valid),   1.0);
      chk("ov_busy",  real'(pd.o_busy),    0.0);
      chk("ov_cur3",  pd.o_real_pd_current[3], 1.5);
      retire();
      chk("ov_idle_valid", real'(pd.o_valid),   0.0);
      chk("ov_idle_busy",  real'(pd.o_busy),    0.0);
      chk("ov_sticky",     real'(pd.o_overrun), 1.0);

      // passband edges (exactly +/-tol) and negative power
      refs[0] = 0.0; waves[0].wavelength =  0.4;
      refs[1] = 0.0; waves[1].wavelength = -0.4;
      waves[2].power = -1.0;
      run_window("w3", 0);
      chk("w3_cur0",   pd.o_real_pd_current[0], 2.0);
      chk("w3_cur1",   pd.o_real_pd_current[1], 2.0);
      chk("w3_cur2",   pd.o_real_pd_current[2], -1.0);
      chk("w3_inband", real'(pd.o_in_band), 255.0);

      // back-to-back: handshake and start on the same edge H
      set_nominal(1.0);
      pd.i_ready     = 1'b1;
      pd.i_acq_start = 1'b1;
      tick();
      pd.i_ready     = 1'b0;
      pd.i_acq_start = 1'b0;
      chk("b2b_busy",  real'(pd.o_busy),  1.0);
      chk("b2b_valid", real'(pd.o_valid), 0.0);
      chk("b2b_hold",  pd.o_real_pd_current[2], -1.0);
      for (int k = 1; k <= W; k++) tick();
      chk("b2b_valid_early", real'(pd.o_valid), 0.0);
      tick();
      chk("b2b_valid_lat", real'(pd.o_valid), 1.0);
      chk("b2b_cur2",      pd.o_real_pd_current[2], 1.0);
      retire();

      // reset on the 8th ACQ sample aborts the window
      set_nominal(2.0);
      pd.i_acq_start = 1'b1;
      tick();
      pd.i_acq_start = 1'b0;
      for (int k = 1; k <= 7; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("ab_valid",   real'(pd.o_valid),   0.0);
      chk("ab_busy",    real'(pd.o_busy),    0.0);
      chk("ab_overrun", real'(pd.o_overrun), 0.0);
      chk("ab_inband",  real'(pd.o_in_band), 0.0);
      chk("ab_cur0",    pd.o_real_pd_current[0], 0.0);
      tick();
      chk("ab_stays_idle", real'(pd.o_busy), 0.0);
      run_window("w4", 0);
      chk("w4_cur0",   pd.o_real_pd_current[0], 2.0);
      chk("w4_cur7",   pd.o_real_pd_current[7], 2.0);
      chk("w4_inband", real'(pd.o_in_band), 255.0);
      retire();
`else
      // dark current only: zero optical power
      set_nominal(0.0);
      run_window("dk", 0);
      for (int i = 0; i < NW; i++) chk($sformatf("dk_cur%0d", i), pd.o_real_pd_current[i], 1.0e-3);
      chk("dk_inband", real'(pd.o_in_band), 255.0);
      chk("dk_total",  dark_total, 8.0e-3);
      retire();
      set_nominal(2.0);
      run_window("dk2", 0);
      chk("dk2_cur0", pd.o_real_pd_current[0], 2.001);
      retire();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
